ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the opposite direction of the kbd_intf receiver on PS2_Clk/PS2_Data.
//  Sends one command byte to the keyboard (e.g. 8'hED LED set, 8'hFF reset) using the PS/2 request-to-send protocol.
//  Both lines are open-drain: the block only pulls them low, via *_oe_o, and top-level tristates them.
//  Raises tx_active_o so kbd_intf discards the frames it sees while a transmission is in progress.
// PARAMETERS
//  INHIBIT_CYCLES  2600     clk25 cycles that PS2_Clk is held low before RTS (104 us, spec minimum 100 us)
//  RTS_TIMEOUT     375000   cycles from clock release to the first device falling edge (15 ms)
//  PKT_TIMEOUT     50000    cycles from the first falling edge to the ack edge (2 ms)
//  FILTER_LEN      8        consecutive equal samples needed to accept a new PS2_Clk level
// PORTS
//  clk25        in   1   system clock, 25 MHz
//  reset_in     in   1   synchronous reset, active-high
//  tx_data_i    in   8   byte to send; captured on an accepted tx_start_i
//  tx_start_i   in   1   one-cycle start request
//  PS2_Clk      in   1   raw PS/2 clock pin (asynchronous)
//  PS2_Data     in   1   raw PS/2 data pin (asynchronous)
//  ps2_clk_oe_o   out  1   1 = pull PS2_Clk low
//  ps2_data_oe_o  out  1   1 = pull PS2_Data low
//  busy_o       out  1   high from an accepted start until done_o
//  tx_active_o  out  1   = busy_o; tells the receiver to ignore the line
//  done_o       out  1   one-cycle pulse at the end of every attempt
//  ack_err_o    out  1   valid with done_o: device did not ack (data high at the 11th falling edge)
//  timeout_o    out  1   valid with done_o: RTS or packet timeout expired
// BEHAVIOUR
//  Reset: every output is 0 and the FSM is in IDLE; line filters preset to 1. A reset mid-frame releases both lines on the next edge.
//  Input conditioning: PS2_Clk and PS2_Data each pass through a 2-flop synchroniser.
//   - PS2_Clk is then filtered (level changes only after FILTER_LEN equal samples).
//   - fall = filtered clock 1 -> 0, a one-cycle strobe.
//  Shift register: shreg[9:0] = {1'b1 stop, ~^tx_data_i odd parity, tx_data_i[7:0]}, loaded on start; LSB goes first.
//  FSM:
//   - IDLE: if tx_start_i, load shreg, clear the flags, busy=1, cnt=0, go to INHIBIT. Starts while busy are ignored (no queueing).
//   - INHIBIT: clk_oe=1, data_oe=0, cnt++. When cnt==INHIBIT_CYCLES-1, set data_oe=1 (start bit) and go to RTS.
//   - RTS: hold data_oe=1 and clk_oe=1 for 1 more cycle, then clk_oe=0, cnt=0, go to WAIT_CLK.
//   - WAIT_CLK: on fall, data_oe=~shreg[0], shift right, bitcnt=1, cnt=0, go to SEND.
//     If cnt reaches RTS_TIMEOUT first, set timeout and go to ABORT.
//   - SEND: on each fall, data_oe=~shreg[0], shift, bitcnt++.
//     The 10th fall drives the stop bit (data_oe=0); when bitcnt==10, go to ACK.
//   - ACK: on the next fall (11th), ack_err = synced PS2_Data, then go to WAIT_IDLE.
//   - WAIT_IDLE: wait until the filtered clock and synced data are both 1, then go to FINISH.
//   - FINISH: done_o=1 for 1 cycle, busy=0, go to IDLE.
//   - ABORT: clk_oe=0, data_oe=0, then go to FINISH.
//   - PKT_TIMEOUT: counted in SEND/ACK/WAIT_IDLE from the first fall (cnt not cleared per edge). On expiry set timeout and go to ABORT.
//  Data changes only right after a falling edge, i.e. while the device holds the clock low. clk_oe is never asserted after RTS.
//  When timeout and ack_err would both apply, only timeout is reported.
//  Latency for a well-behaved device: INHIBIT_CYCLES + 2 + 11 device clock periods + filter delay.
// STRUCTURE
//  Package bk_ps2_pkg:
//   - state enum (IDLE, INHIBIT, RTS, WAIT_CLK, SEND, ACK, WAIT_IDLE, ABORT, FINISH)
//   - command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, ACK_BYTE=8'hFA
//  Sub-module ps2_line_filter: synchroniser + FILTER_LEN glitch filter + fall strobe.
//   - Also reusable by kbd_intf; here only the clock uses the filter.
//  One shared 19-bit cnt serves the inhibit, RTS and packet timers.
// TESTING
//  1. Send 8'hED with a device model clocking at 12.5 kHz and acking.
//     -> clock low >= 2600 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_err=0, timeout=0.
//  2. Send 8'h01 -> parity bit 0. Send 8'h00 -> parity bit 1. Data is stable from every fall to the next rise.
//  3. Device never clocks -> done at 375000+2600+2 cycles (plus filter delay), timeout=1, both oe=0.
//  4. Device leaves data high at the 11th edge -> done with ack_err=1, timeout=0.
//  5. Assert reset_in during bit 4 -> next cycle both oe=0 and busy=0. A new start then succeeds.
//  6. Pulse tx_start_i while busy -> ignored, the byte on the wire is unchanged.
//     Inject a 3-cycle clock glitch -> no extra bit is shifted.

Source files
------------

// File: rtl/bk_ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
//  state_t   : host transmitter FSM states
//  CMD_*     : common keyboard command bytes, ACK_BYTE is the keyboard's reply
//  cnt_t     : shared 19-bit timer type (inhibit, RTS and packet timers)
//  frame_word: {stop, odd parity, data}, shifted out LSB first
package bk_ps2_pkg;

  typedef enum logic [3:0] {
    IDLE, INHIBIT, RTS, WAIT_CLK, SEND, ACK, WAIT_IDLE, ABORT, FINISH
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  localparam int CNT_W = 19;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [9:0] frame_word(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
//  tx_data_i/tx_start_i : byte and one-cycle start request (controller -> tx)
//  busy_o/tx_active_o   : attempt in progress (tx_active_o also gates kbd_intf)
//  done_o               : one-cycle end-of-attempt pulse
//  ack_err_o/timeout_o  : attempt result, valid with done_o
interface ps2_host_tx_if;
  logic [7:0] tx_data_i;
  logic       tx_start_i;
  logic       busy_o;
  logic       tx_active_o;
  logic       done_o;
  logic       ack_err_o;
  logic       timeout_o;

  modport master (
    output tx_data_i, tx_start_i,
    input  busy_o, tx_active_o, done_o, ack_err_o, timeout_o
  );

  modport slave (
    input  tx_data_i, tx_start_i,
    output busy_o, tx_active_o, done_o, ack_err_o, timeout_o
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser + glitch filter for a raw PS/2 line.
//  clk25, reset_in : system clock, synchronous active-high reset
//  raw             : asynchronous pin
//  level           : filtered level; changes only after FILTER_LEN equal samples
//  fall            : one-cycle strobe, coincident with level going 1 -> 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk25,
  input  logic reset_in,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] run;

  always_ff @(posedge clk25) begin
    if (reset_in) begin
      sync  <= 2'b11;
      level <= 1'b1;
      run   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      // run counts consecutive samples that disagree with the accepted level
      if (sync[1] != level) begin
        if (run == CW'(FILTER_LEN - 1)) begin
          level <= sync[1];
          run   <= '0;
          fall  <= level;
        end else begin
          run <= run + 1'b1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter (request-to-send, one byte per attempt).
//  clk25, reset_in          : 25 MHz clock, synchronous active-high reset
//  bus (slave)              : command handshake, see ps2_host_tx_if
//  PS2_Clk, PS2_Data        : raw open-drain pins (asynchronous)
//  ps2_clk_oe_o             : 1 = pull PS2_Clk low
//  ps2_data_oe_o            : 1 = pull PS2_Data low
module ps2_host_tx
  import bk_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2600,
  parameter int RTS_TIMEOUT    = 375000,
  parameter int PKT_TIMEOUT    = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk25,
  input  logic         reset_in,
  ps2_host_tx_if.slave bus,
  input  logic         PS2_Clk,
  input  logic         PS2_Data,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o
);

  localparam cnt_t INH_LAST = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t RTS_LAST = cnt_t'(RTS_TIMEOUT - 1);
  localparam cnt_t PKT_LAST = cnt_t'(PKT_TIMEOUT - 1);

  state_t     state;
  logic [9:0] shreg;
  logic [3:0] bitcnt;
  cnt_t       cnt;
  logic [1:0] data_sync;
  logic       clk_f, fall;
  logic       busy, done, ack_err, timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk25    (clk25),
    .reset_in (reset_in),
    .raw      (PS2_Clk),
    .level    (clk_f),
    .fall     (fall)
  );

  always_ff @(posedge clk25) begin
    if (reset_in) data_sync <= 2'b11;
    else          data_sync <= {data_sync[0], PS2_Data};
  end

  assign bus.busy_o      = busy;
  assign bus.tx_active_o = busy;
  assign bus.done_o      = done;
  assign bus.ack_err_o   = ack_err;
  assign bus.timeout_o   = timeout;

  // Packet timer runs from the first device fall; it is not restarted per edge.
  wire pkt_expired = (cnt == PKT_LAST);

  always_ff @(posedge clk25) begin
    if (reset_in) begin
      state         <= IDLE;
      shreg         <= '1;
      bitcnt        <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ack_err       <= 1'b0;
      timeout       <= 1'b0;
      ps2_clk_oe_o  <= 1'b0;
      ps2_data_oe_o <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.tx_start_i) begin
          shreg        <= frame_word(bus.tx_data_i);
          ack_err      <= 1'b0;
          timeout      <= 1'b0;
          busy         <= 1'b1;
          cnt          <= '0;
          ps2_clk_oe_o <= 1'b1;
          state        <= INHIBIT;
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == INH_LAST) begin
            ps2_data_oe_o <= 1'b1;  // start bit, clock still held
            state         <= RTS;
          end
        end
        RTS: begin
          ps2_clk_oe_o <= 1'b0;
          cnt          <= '0;
          state        <= WAIT_CLK;
        end
        WAIT_CLK: begin
          if (fall) begin
            ps2_data_oe_o <= ~shreg[0];
            shreg         <= {1'b1, shreg[9:1]};
            bitcnt        <= 4'd1;
            cnt           <= '0;
            state         <= SEND;
          end else if (cnt == RTS_LAST) begin
            timeout <= 1'b1;
            state   <= ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SEND: begin
          cnt <= cnt + 1'b1;
          if (pkt_expired) begin
            timeout <= 1'b1;
            state   <= ABORT;
          end else if (fall) begin
            ps2_data_oe_o <= ~shreg[0];
            shreg         <= {1'b1, shreg[9:1]};
            bitcnt        <= bitcnt + 1'b1;
            if (bitcnt == 4'd9) state <= ACK;  // this fall drove the stop bit
          end
        end
        ACK: begin
          cnt <= cnt + 1'b1;
          if (pkt_expired) begin
            timeout <= 1'b1;
            state   <= ABORT;
          end else if (fall) begin
            ack_err <= data_sync[1];
            state   <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (pkt_expired) begin
            timeout <= 1'b1;
            ack_err <= 1'b0;  // a timeout hides any ack error
            state   <= ABORT;
          end else if (clk_f && data_sync[1]) begin
            state <= FINISH;
          end
        end
        ABORT: begin
          ps2_clk_oe_o  <= 1'b0;
          ps2_data_oe_o <= 1'b0;
          state         <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
